// File: rtl/instr_register_pkg.sv
// -----------------------------------------------------------------------------
// instr_register_pkg
// Shared types for the pipelined instruction register:
//   OP_W          default operand width; instruction_t is sized from it
//   opcode_t      3-bit operation code
//   instruction_t {opc, op_a, op_b, result}, result is 2*OP_W wide
// -----------------------------------------------------------------------------
package instr_register_pkg;

    localparam int OP_W = 32;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef struct packed {
        opcode_t                  opc;
        logic signed [OP_W-1:0]   op_a;
        logic signed [OP_W-1:0]   op_b;
        logic signed [2*OP_W-1:0] result;
    } instruction_t;

endpackage

// File: rtl/instr_register_pipe_if.sv
// -----------------------------------------------------------------------------
// instr_register_pipe_if
// Bus between the stimulus side and the instruction register.
//   master : drives load_en/write_pointer/opcode/operands/read_en/read_pointer,
//            observes instruction_word/rd_valid/rd_err/wr_ptr_q/entry_count/full
//   slave  : the register itself (opposite directions)
// PTR_W must equal $clog2(DEPTH) of the attached register.
// -----------------------------------------------------------------------------
interface instr_register_pipe_if #(
    parameter int PTR_W = 5
) ();
    import instr_register_pkg::*;

    logic                   load_en;
    logic [PTR_W-1:0]       write_pointer;
    opcode_t                opcode;
    logic signed [OP_W-1:0] operand_a;
    logic signed [OP_W-1:0] operand_b;
    logic                   read_en;
    logic [PTR_W-1:0]       read_pointer;
    instruction_t           instruction_word;
    logic                   rd_valid;
    logic                   rd_err;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W:0]         entry_count;
    logic                   full;

    modport master (
        output load_en, write_pointer, opcode, operand_a, operand_b,
               read_en, read_pointer,
        input  instruction_word, rd_valid, rd_err, wr_ptr_q, entry_count, full
    );

    modport slave (
        input  load_en, write_pointer, opcode, operand_a, operand_b,
               read_en, read_pointer,
        output instruction_word, rd_valid, rd_err, wr_ptr_q, entry_count, full
    );

endinterface

// File: rtl/instr_alu.sv
// -----------------------------------------------------------------------------
// instr_alu
// Combinational result for one instruction. Operands are sign-extended to
// 2*OP_W before the operation, so MULT keeps its full product.
//   opcode_i  operation
//   a_i, b_i  signed operands
//   result_o  signed 2*OP_W result
//   err_o     DIV/MOD by zero (result_o forced to 0 in that case)
// -----------------------------------------------------------------------------
module instr_alu #(
    parameter int OP_W = instr_register_pkg::OP_W
) (
    input  instr_register_pkg::opcode_t opcode_i,
    input  logic signed [OP_W-1:0]      a_i,
    input  logic signed [OP_W-1:0]      b_i,
    output logic signed [2*OP_W-1:0]    result_o,
    output logic                        err_o
);
    import instr_register_pkg::*;

    logic signed [2*OP_W-1:0] a_ext;
    logic signed [2*OP_W-1:0] b_ext;

    assign a_ext = {{OP_W{a_i[OP_W-1]}}, a_i};
    assign b_ext = {{OP_W{b_i[OP_W-1]}}, b_i};

    always_comb begin
        result_o = '0;
        err_o    = 1'b0;
        case (opcode_i)
            ZERO:  result_o = '0;
            PASSA: result_o = a_ext;
            PASSB: result_o = b_ext;
            ADD:   result_o = a_ext + b_ext;
            SUB:   result_o = a_ext - b_ext;
            MULT:  result_o = a_ext * b_ext;
            // Signed '/' truncates toward zero and '%' takes the sign of a.
            DIV: begin
                if (b_i == '0) err_o = 1'b1;
                else           result_o = a_ext / b_ext;
            end
            MOD: begin
                if (b_i == '0) err_o = 1'b1;
                else           result_o = a_ext % b_ext;
            end
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/instr_register_pipe.sv
// -----------------------------------------------------------------------------
// instr_register_pipe
// DEPTH-entry instruction store with a two-stage write pipeline
// (S1 capture, S2 compute + commit), per-entry valid/error flags,
// optional auto-increment write addressing and a 1-cycle registered read.
//   clk, reset  single clock, synchronous active-high reset
//   bus         instr_register_pipe_if.slave (write request, read request,
//               instruction_word/rd_valid/rd_err, wr_ptr_q, entry_count, full)
// OP_W must match instr_register_pkg::OP_W because instruction_t is sized
// from the package.
// -----------------------------------------------------------------------------
module instr_register_pipe #(
    parameter int OP_W     = instr_register_pkg::OP_W,
    parameter int DEPTH    = 32,
    parameter int PTR_W    = $clog2(DEPTH),
    parameter bit AUTO_INC = 1'b0
) (
    input logic                  clk,
    input logic                  reset,
    instr_register_pipe_if.slave bus
);
    import instr_register_pkg::*;

    // Storage. Entry data is not reset: an entry is only visible through
    // its valid bit, which reset clears.
    instruction_t     mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] err_q;

    logic                   s1_vld_q;
    logic [PTR_W-1:0]       s1_addr_q;
    opcode_t                s1_opc_q;
    logic signed [OP_W-1:0] s1_a_q;
    logic signed [OP_W-1:0] s1_b_q;

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_addr_d;
    logic [PTR_W:0]   count_q;

    instruction_t rd_word_q, rd_word_d;
    logic         rd_valid_q, rd_valid_d;
    logic         rd_err_q, rd_err_d;

    logic signed [2*OP_W-1:0] alu_result;
    logic                     alu_err;
    instruction_t             commit_word;

    assign wr_addr_d = AUTO_INC ? wr_ptr_q : bus.write_pointer;

    // ---- S1: capture write request ----
    always_ff @(posedge clk) begin
        if (bus.load_en) begin
            s1_addr_q <= wr_addr_d;
            s1_opc_q  <= bus.opcode;
            s1_a_q    <= bus.operand_a;
            s1_b_q    <= bus.operand_b;
        end
    end

    // ---- S2: compute result and commit ----
    instr_alu #(.OP_W(OP_W)) u_alu (
        .opcode_i (s1_opc_q),
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .result_o (alu_result),
        .err_o    (alu_err)
    );

    assign commit_word = '{opc: s1_opc_q, op_a: s1_a_q, op_b: s1_b_q, result: alu_result};

    always_ff @(posedge clk) begin
        if (s1_vld_q && !reset) mem_q[s1_addr_q] <= commit_word;
    end

    // Read port: a commit landing on the read address this same edge is
    // forwarded so the read sees the new data (write-first).
    always_comb begin
        rd_word_d  = rd_word_q;
        rd_valid_d = rd_valid_q;
        rd_err_d   = rd_err_q;
        if (bus.read_en) begin
            if (s1_vld_q && (s1_addr_q == bus.read_pointer)) begin
                rd_word_d  = commit_word;
                rd_valid_d = 1'b1;
                rd_err_d   = alu_err;
            end else if (valid_q[bus.read_pointer]) begin
                rd_word_d  = mem_q[bus.read_pointer];
                rd_valid_d = 1'b1;
                rd_err_d   = err_q[bus.read_pointer];
            end else begin
                rd_word_d  = '0;
                rd_valid_d = 1'b0;
                rd_err_d   = 1'b0;
            end
        end
    end

    // Control state; reset drops any write sitting in S1.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q   <= 1'b0;
            valid_q    <= '0;
            err_q      <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rd_word_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            s1_vld_q <= bus.load_en;
            // Power-of-2 DEPTH makes the natural overflow the wrap to 0.
            if (AUTO_INC && bus.load_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (s1_vld_q) begin
                valid_q[s1_addr_q] <= 1'b1;
                err_q[s1_addr_q]   <= alu_err;
                if (!valid_q[s1_addr_q]) count_q <= count_q + (PTR_W+1)'(1);
            end
            rd_word_q  <= rd_word_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign bus.instruction_word = rd_word_q;
    assign bus.rd_valid         = rd_valid_q;
    assign bus.rd_err           = rd_err_q;
    assign bus.wr_ptr_q         = wr_ptr_q;
    assign bus.entry_count      = count_q;
    assign bus.full             = (count_q == (PTR_W+1)'(DEPTH));

endmodule

// File: tb/tb_instr_register_pipe.sv
// -----------------------------------------------------------------------------
// tb_instr_register_pipe
// Two instances: u0 (DEPTH=32, explicit addressing) and u1 (DEPTH=4,
// auto-increment). A behavioural model tracks the expected register
// contents; a negedge process compares every output of both instances
// every cycle, and directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_instr_register_pipe;
    import instr_register_pkg::*;

    logic clk;
    logic reset;
    bit   chk_en;
    int   nchecks;
    int   nfail;

    instr_register_pipe_if #(.PTR_W(5)) bus0 ();
    instr_register_pipe_if #(.PTR_W(2)) bus1 ();

    instr_register_pipe #(.DEPTH(32), .AUTO_INC(1'b0)) u0 (
        .clk(clk), .reset(reset), .bus(bus0.slave)
    );
    instr_register_pipe #(.DEPTH(4), .AUTO_INC(1'b1)) u1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, nfail=%0d", nfail);
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    bit           mv   [2][32];
    instruction_t mw   [2][32];
    bit           me   [2][32];
    bit           pv   [2];
    int           pa   [2];
    instruction_t pw   [2];
    bit           pe   [2];
    int           mptr [2];
    instruction_t xw   [2];
    bit           xv   [2];
    bit           xe   [2];

    function automatic longint ref_result(opcode_t opc, int a, int b, output bit err);
        longint la = a;
        longint lb = b;
        err = 1'b0;
        case (opc)
            ZERO:  return 0;
            PASSA: return la;
            PASSB: return lb;
            ADD:   return la + lb;
            SUB:   return la - lb;
            MULT:  return la * lb;
            DIV:   begin if (lb == 0) begin err = 1'b1; return 0; end return la / lb; end
            MOD:   begin if (lb == 0) begin err = 1'b1; return 0; end return la % lb; end
            default: return 0;
        endcase
    endfunction

    task automatic model_step(int k, int depth, bit ai, bit rst, bit le, int wp,
                              opcode_t opc, int a, int b, bit re, int rp);
        bit     e;
        longint r;
        int     addr;
        if (rst) begin
            for (int i = 0; i < 32; i++) mv[k][i] = 1'b0;
            pv[k] = 1'b0; mptr[k] = 0;
            xw[k] = '0; xv[k] = 1'b0; xe[k] = 1'b0;
            return;
        end
        if (pv[k]) begin
            mv[k][pa[k]] = 1'b1; mw[k][pa[k]] = pw[k]; me[k][pa[k]] = pe[k];
        end
        if (re) begin
            if (mv[k][rp]) begin xw[k] = mw[k][rp]; xv[k] = 1'b1; xe[k] = me[k][rp]; end
            else           begin xw[k] = '0;        xv[k] = 1'b0; xe[k] = 1'b0;       end
        end
        pv[k] = le;
        if (le) begin
            addr  = ai ? mptr[k] : wp;
            r     = ref_result(opc, a, b, e);
            pa[k] = addr;
            pw[k] = '{opc: opc, op_a: a, op_b: b, result: r};
            pe[k] = e;
            if (ai) mptr[k] = (mptr[k] + 1) % depth;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 32, 1'b0, reset, bus0.load_en, int'(bus0.write_pointer), bus0.opcode,
                   bus0.operand_a, bus0.operand_b, bus0.read_en, int'(bus0.read_pointer));
        model_step(1, 4, 1'b1, reset, bus1.load_en, int'(bus1.write_pointer), bus1.opcode,
                   bus1.operand_a, bus1.operand_b, bus1.read_en, int'(bus1.read_pointer));
    end

    // ---------------- checking ----------------
    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp(int k, int depth, instruction_t w, logic v, logic e,
                       logic [5:0] p, logic [5:0] c, logic f);
        int cnt = 0;
        for (int i = 0; i < depth; i++) cnt += int'(mv[k][i]);
        chk($sformatf("u%0d.word", k),  w, xw[k]);
        chk($sformatf("u%0d.valid", k), v, xv[k]);
        chk($sformatf("u%0d.err", k),   e, xe[k]);
        chk($sformatf("u%0d.wr_ptr", k), p, 6'(mptr[k]));
        chk($sformatf("u%0d.count", k), c, 6'(cnt));
        chk($sformatf("u%0d.full", k),  f, (cnt == depth));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, 32, bus0.instruction_word, bus0.rd_valid, bus0.rd_err,
                6'(bus0.wr_ptr_q), 6'(bus0.entry_count), bus0.full);
            cmp(1, 4, bus1.instruction_word, bus1.rd_valid, bus1.rd_err,
                6'(bus1.wr_ptr_q), 6'(bus1.entry_count), bus1.full);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle1_now();
        bus1.load_en = 1'b0; bus1.write_pointer = '0; bus1.opcode = ZERO;
        bus1.operand_a = '0; bus1.operand_b = '0; bus1.read_en = 1'b0; bus1.read_pointer = '0;
    endtask

    task automatic cyc0(bit rst, bit le, int wp, opcode_t opc, int a, int b, bit re, int rp);
        @(negedge clk);
        reset = rst;
        bus0.load_en = le; bus0.write_pointer = 5'(wp); bus0.opcode = opc;
        bus0.operand_a = a; bus0.operand_b = b;
        bus0.read_en = re; bus0.read_pointer = 5'(rp);
        idle1_now();
    endtask

    task automatic cyc1(bit le, opcode_t opc, int a, int b, bit re, int rp);
        @(negedge clk);
        reset = 1'b0;
        bus0.load_en = 1'b0; bus0.read_en = 1'b0;
        bus1.load_en = le; bus1.write_pointer = 2'($urandom_range(0, 3)); bus1.opcode = opc;
        bus1.operand_a = a; bus1.operand_b = b;
        bus1.read_en = re; bus1.read_pointer = 2'(rp);
    endtask

    task automatic wr0(int wp, opcode_t opc, int a, int b); cyc0(0, 1, wp, opc, a, b, 0, 0); endtask
    task automatic rd0(int rp); cyc0(0, 0, 0, ZERO, 0, 0, 1, rp); endtask
    task automatic idle(); cyc0(0, 0, 0, ZERO, 0, 0, 0, 0); endtask
    task automatic rst_cyc(); cyc0(1, 0, 0, ZERO, 0, 0, 0, 0); endtask

    function automatic int rand_op();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return int'($urandom_range(0, 20)) - 10;
            default: return int'($urandom);
        endcase
    endfunction

    initial begin
        nchecks = 0; nfail = 0; chk_en = 1'b0;
        reset = 1'b1;
        bus0.load_en = 1'b0; bus0.write_pointer = '0; bus0.opcode = ZERO;
        bus0.operand_a = '0; bus0.operand_b = '0; bus0.read_en = 1'b0; bus0.read_pointer = '0;
        idle1_now();
        repeat (2) @(posedge clk);
        chk_en = 1'b1;

        // Reset after a committed write
        wr0(1, ADD, 1, 1); idle(); idle();
        rst_cyc(); rst_cyc();
        rd0(1); idle();
        chk("reset.rd_valid", bus0.rd_valid, 1'b0);
        chk("reset.count", bus0.entry_count, 6'd0);
        chk("reset.wr_ptr", bus1.wr_ptr_q, 2'd0);

        // Basic write/read
        wr0(2, ADD, 5, -3); wr0(3, MULT, -4, 7); idle();
        rd0(2); idle();
        chk("basic.rd2.result", $signed(bus0.instruction_word.result), 2);
        chk("basic.rd2.valid", bus0.rd_valid, 1'b1);
        rd0(3); idle();
        chk("basic.rd3.result", $signed(bus0.instruction_word.result), -28);
        chk("basic.count", bus0.entry_count, 6'd2);

        // Divide by zero and signed modulo
        wr0(5, DIV, 9, 0); wr0(6, MOD, -7, 2); idle();
        rd0(5); idle();
        chk("div0.result", $signed(bus0.instruction_word.result), 0);
        chk("div0.err", bus0.rd_err, 1'b1);
        rd0(6); idle();
        chk("mod.result", $signed(bus0.instruction_word.result), -1);
        chk("mod.err", bus0.rd_err, 1'b0);

        // Write-first hazard: read lands on the commit edge
        wr0(4, ADD, 100, 1); rd0(4); idle();
        chk("hazard.write_first", $signed(bus0.instruction_word.result), 101);
        // Read on the capture edge sees old contents
        cyc0(0, 1, 4, SUB, 10, 3, 1, 4); idle();
        chk("hazard.old", $signed(bus0.instruction_word.result), 101);
        rd0(4); idle();
        chk("hazard.new", $signed(bus0.instruction_word.result), 7);
        chk("hazard.count", bus0.entry_count, 6'd5);

        // Reset on the edge after load_en
        wr0(7, PASSA, 42, 0); rst_cyc(); idle();
        rd0(7); idle();
        chk("midreset.valid", bus0.rd_valid, 1'b0);
        chk("midreset.count", bus0.entry_count, 6'd0);

        // Auto-increment wrap on the DEPTH=4 instance
        for (int i = 0; i < 5; i++) cyc1(1, PASSA, 10 + i, 0, 0, 0);
        cyc1(0, ZERO, 0, 0, 0, 0);
        cyc1(0, ZERO, 0, 0, 0, 0);
        chk("wrap.wr_ptr", bus1.wr_ptr_q, 2'd1);
        chk("wrap.count", bus1.entry_count, 3'd4);
        chk("wrap.full", bus1.full, 1'b1);
        cyc1(0, ZERO, 0, 0, 1, 0);
        cyc1(0, ZERO, 0, 0, 0, 0);
        chk("wrap.entry0", $signed(bus1.instruction_word.result), 14);

        // Randomized traffic on both instances
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 99) == 0);
            bus0.load_en = 1'($urandom_range(0, 1));
            bus0.write_pointer = 5'($urandom_range(0, 31));
            bus0.opcode = opcode_t'($urandom_range(0, 7));
            bus0.operand_a = rand_op(); bus0.operand_b = rand_op();
            bus0.read_en = 1'($urandom_range(0, 1));
            bus0.read_pointer = 5'($urandom_range(0, 31));
            bus1.load_en = 1'($urandom_range(0, 1));
            bus1.write_pointer = 2'($urandom_range(0, 3));
            bus1.opcode = opcode_t'($urandom_range(0, 7));
            bus1.operand_a = rand_op(); bus1.operand_b = rand_op();
            bus1.read_en = 1'($urandom_range(0, 1));
            bus1.read_pointer = 2'($urandom_range(0, 3));
        end
        idle(); idle();

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
